wb_pattern_master: RTL



---
 rtl/wb_pattern_master_if.sv | 46 ++++
 rtl/wb_pattern_master.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_pattern_master_if.sv
// -----------------------------------------------------------------------------
// wb_pattern_master_if
// Wishbone bus bundle between the pattern master and the SDRAM controller
// host port. The suffixes follow the master's point of view (_o driven by
// the master, _i driven by the slave).
//
// Signals:
//   wb_cyc_o   cycle valid
//   wb_stb_o   strobe
//   wb_we_o    write enable
//   wb_addr_o  26-bit byte address
//   wb_dat_o   write data, DW bits
//   wb_sel_o   byte enables, DW/8 bits
//   wb_cti_o   cycle type identifier
//   wb_ack_i   slave acknowledge
//   wb_dat_i   read data, DW bits
//
// Modports: master (pattern generator side), slave (memory controller side).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface wb_pattern_master_if #(
   parameter int DW = 32
);
   logic            wb_cyc_o;
   logic            wb_stb_o;
   logic            wb_we_o;
   logic [25:0]     wb_addr_o;
   logic [DW-1:0]   wb_dat_o;
   logic [DW/8-1:0] wb_sel_o;
   logic [2:0]      wb_cti_o;
   logic            wb_ack_i;
   logic [DW-1:0]   wb_dat_i;

   // The initiator drives the request side and listens to ack/read data.
   modport master (
      output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
      input  wb_ack_i, wb_dat_i
   );

   // The memory controller sees the request side and answers with ack/data.
   modport slave (
      input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
      output wb_ack_i, wb_dat_i
   );
endinterface

// File: rtl/wb_pattern_master.sv
// -----------------------------------------------------------------------------
// wb_pattern_master
// Wishbone initiator for SDRAM bring-up. On start it writes an incrementing
// pattern (SEED + k) to a contiguous byte-address range, waits one idle gap
// cycle, reads the same range back and counts every word that differs from
// the pattern. The result is left in err_cnt when the done pulse fires.
//
// Parameters:
//   dw    data width in bits (byte lanes = dw/8)
//   SEED  pattern base value, word k = SEED + k
//
// Ports:
//   sys_clk        system / Wishbone clock
//   RESETN         synchronous active-low reset
//   sdr_init_done  SDRAM controller finished its init sequence
//   start          one-cycle test request, only honoured while idle
//   base_addr      first byte address, captured on start
//   burst_len      beats per phase, 0 means 256, captured on start
//   busy           test in progress (accepted start until the done cycle)
//   done           one-cycle pulse at the end of the test
//   err_cnt        read mismatches plus watchdog aborts, saturating
//   timeout        watchdog abort flag, sticky until the next start
//   wb             Wishbone master modport
//
// Optional feature macro: WB_TIMEOUT_EN
//   Defined   : a 10-bit watchdog aborts a phase after 1023 unacked strobe
//               cycles, sets timeout and bumps err_cnt.
//   Undefined : the master waits for ack forever and timeout is tied low.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module wb_pattern_master #(
   parameter int            dw   = 32,
   parameter logic [dw-1:0] SEED = 32'hA5A5_0000
) (
   input  logic                   sys_clk,
   input  logic                   RESETN,
   input  logic                   sdr_init_done,
   input  logic                   start,
   input  logic [25:0]            base_addr,
   input  logic [7:0]             burst_len,
   output logic                   busy,
   output logic                   done,
   output logic [31:0]            err_cnt,
   output logic                   timeout,
   wb_pattern_master_if.master    wb
);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_INIT,
      WRITE,
      GAP,
      READ,
      DONE
   } state_t;

   localparam logic [25:0]   ADDR_STEP = 26'(dw/8);
   localparam logic [dw-1:0] DATA_STEP = {{(dw-1){1'b0}}, 1'b1};

   state_t          r_state;
   state_t          w_nextState;
   logic [25:0]     r_base;
   logic [7:0]      r_lastIdx;
   logic [7:0]      r_k;
   logic [25:0]     r_addr;
   logic [dw-1:0]   r_dat;
   logic [31:0]     r_errCnt;

   logic            w_inPhase;
   logic            w_ack;
   logic            w_lastBeat;
   logic            w_mismatch;
   logic            w_abort;
   logic            w_errInc;
   logic            w_stb;
   logic            w_we;
   logic            w_busy;
   logic            w_done;

   // Ack is only meaningful while a phase is strobing; anything the slave
   // asserts outside WRITE/READ is ignored. Storing burst_len-1 lets the
   // 8-bit wrap turn a length of 0 into a last index of 255 (256 beats).
   assign w_inPhase  = (r_state == WRITE) || (r_state == READ);
   assign w_ack      = w_inPhase && wb.wb_ack_i;
   assign w_lastBeat = (r_k == r_lastIdx);
   assign w_mismatch = (wb.wb_dat_i != r_dat);
   assign w_errInc   = ((r_state == READ) && w_ack && w_mismatch) || w_abort;

`ifdef WB_TIMEOUT_EN
   logic [9:0] r_wdog;
   logic       r_timeout;

   // The watchdog counts strobe cycles without ack and restarts on every ack
   // or whenever no phase is active. The abort fires on the cycle that would
   // bring the count to 1023, so the strobe is seen for exactly 1023 cycles.
   assign w_abort = w_inPhase && !wb.wb_ack_i && (r_wdog == 10'd1022);
   assign timeout = r_timeout;

   // Watchdog counter plus the sticky timeout flag, cleared by a new start.
   always_ff @(posedge sys_clk) begin
      if (!RESETN) begin
         r_wdog    <= '0;
         r_timeout <= 1'b0;
      end else begin
         if (!w_inPhase || wb.wb_ack_i || w_abort) begin
            r_wdog <= '0;
         end else begin
            r_wdog <= r_wdog + 10'd1;
         end
         if ((r_state == IDLE) && start) begin
            r_timeout <= 1'b0;
         end else if (w_abort) begin
            r_timeout <= 1'b1;
         end
      end
   end
`else
   assign w_abort = 1'b0;
   assign timeout = 1'b0;
`endif

   // State register. The synchronous reset lands on IDLE, which drops
   // cyc/stb on the very next edge without any cleanup beat.
   always_ff @(posedge sys_clk) begin
      if (!RESETN) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state and bus control decode. Strobe is held high for the whole
   // phase; the address and data registers advance on each accepted beat.
   always_comb begin
      w_nextState = r_state;
      w_stb       = 1'b0;
      w_we        = 1'b0;
      w_busy      = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_nextState = WAIT_INIT;
            end
         end
         WAIT_INIT: begin
            w_busy = 1'b1;
            if (sdr_init_done) begin
               w_nextState = WRITE;
            end
         end
         WRITE: begin
            w_busy = 1'b1;
            w_stb  = 1'b1;
            w_we   = 1'b1;
            if (w_abort) begin
               w_nextState = DONE;
            end else if (w_ack && w_lastBeat) begin
               w_nextState = GAP;
            end
         end
         GAP: begin
            w_busy      = 1'b1;
            w_nextState = READ;
         end
         READ: begin
            w_busy = 1'b1;
            w_stb  = 1'b1;
            if (w_abort || (w_ack && w_lastBeat)) begin
               w_nextState = DONE;
            end
         end
         DONE: begin
            w_done      = 1'b1;
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Datapath: capture the test parameters on start, step the beat index,
   // address and expected pattern on each ack, and rewind them in the gap so
   // the read phase walks exactly the same sequence. The error counter
   // saturates instead of wrapping.
   always_ff @(posedge sys_clk) begin
      if (!RESETN) begin
         r_base    <= '0;
         r_lastIdx <= '0;
         r_k       <= '0;
         r_addr    <= '0;
         r_dat     <= '0;
         r_errCnt  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_base    <= base_addr;
                  r_lastIdx <= burst_len - 8'd1;
                  r_k       <= '0;
                  r_addr    <= base_addr;
                  r_dat     <= SEED;
                  r_errCnt  <= '0;
               end
            end
            WRITE, READ: begin
               if (w_ack) begin
                  r_k    <= r_k + 8'd1;
                  r_addr <= r_addr + ADDR_STEP;
                  r_dat  <= r_dat + DATA_STEP;
               end
            end
            GAP: begin
               r_k    <= '0;
               r_addr <= r_base;
               r_dat  <= SEED;
            end
            default: begin
            end
         endcase
         if (w_errInc && !(&r_errCnt)) begin
            r_errCnt <= r_errCnt + 32'd1;
         end
      end
   end

   // Bus outputs are forced to zero whenever no beat is being presented, so
   // the idle and reset bus is all zeros.
   assign wb.wb_cyc_o  = w_stb;
   assign wb.wb_stb_o  = w_stb;
   assign wb.wb_we_o   = w_we;
   assign wb.wb_addr_o = w_stb ? r_addr : '0;
   assign wb.wb_dat_o  = w_we ? r_dat : '0;
   assign wb.wb_sel_o  = {(dw/8){w_stb}};
   assign wb.wb_cti_o  = !w_stb ? 3'b000 : (w_lastBeat ? 3'b111 : 3'b010);

   assign busy    = w_busy;
   assign done    = w_done;
   assign err_cnt = r_errCnt;

endmodule
